// File: rtl/uart_tx.sv
// rtl/uart_tx.sv - UART transmitter with word FIFO, optional parity, x16 tick timing
//
// Ports:
//   clk          system clock
//   rst_n        asynchronous active-low reset
//   s_tick       baud x16 enable pulse, one clk wide
//   din          word to send (DBIT bits)
//   din_valid    din is valid this cycle
//   din_ready    FIFO can accept a word (not full)
//   tx           registered serial line, idle high
//   tx_done_tick one-clk pulse when a frame's last stop tick completes
//   tx_busy      frame in progress or words still queued
module uart_tx #(
    parameter int DBIT       = 8,
    parameter int SB_TICK    = 16,
    parameter int PARITY     = 0,
    parameter int FIFO_DEPTH = 4
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            s_tick,
    input  logic [DBIT-1:0] din,
    input  logic            din_valid,
    output logic            din_ready,
    output logic            tx,
    output logic            tx_done_tick,
    output logic            tx_busy
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int SW = $clog2(SB_TICK);
    localparam int NW = (DBIT > 1) ? $clog2(DBIT) : 1;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_START = 3'd1,
        ST_DATA  = 3'd2,
        ST_PAR   = 3'd3,
        ST_STOP  = 3'd4
    } state_t;

    // FIFO: pointers carry one extra wrap bit to tell full from empty
    logic [DBIT-1:0] mem [FIFO_DEPTH];
    logic [AW:0]     wr_ptr, rd_ptr;
    logic            full, empty, push, pop;
    logic [DBIT-1:0] fifo_dout;
    logic            par_bit;

    assign full      = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign empty     = (wr_ptr == rd_ptr);
    assign din_ready = !full;
    assign push      = din_valid && !full;
    assign fifo_dout = mem[rd_ptr[AW-1:0]];
    // Parity is taken from the word as it leaves the FIFO, before any shifting
    assign par_bit   = (PARITY == 2) ? ~^fifo_dout : ^fifo_dout;

    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr[AW-1:0]] <= din;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + (AW+1)'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + (AW+1)'(1);
            end
        end
    end

    // Frame FSM
    state_t          state, state_n;
    logic [SW-1:0]   s, s_n;
    logic [NW-1:0]   n, n_n;
    logic [DBIT-1:0] b, b_n;
    logic            p, p_n;
    logic            tx_n, done_n;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= ST_IDLE;
            s            <= '0;
            n            <= '0;
            b            <= '0;
            p            <= 1'b0;
            tx           <= 1'b1;
            tx_done_tick <= 1'b0;
        end else begin
            state        <= state_n;
            s            <= s_n;
            n            <= n_n;
            b            <= b_n;
            p            <= p_n;
            tx           <= tx_n;
            tx_done_tick <= done_n;
        end
    end

    always_comb begin
        state_n = state;
        s_n     = s;
        n_n     = n;
        b_n     = b;
        p_n     = p;
        pop     = 1'b0;
        case (state)
            ST_IDLE: begin
                if (s_tick && !empty) begin
                    pop     = 1'b1;
                    b_n     = fifo_dout;
                    p_n     = par_bit;
                    s_n     = '0;
                    state_n = ST_START;
                end
            end
            ST_START: begin
                if (s_tick) begin
                    if (s == SW'(15)) begin
                        s_n     = '0;
                        n_n     = '0;
                        state_n = ST_DATA;
                    end else begin
                        s_n = s + SW'(1);
                    end
                end
            end
            ST_DATA: begin
                if (s_tick) begin
                    if (s == SW'(15)) begin
                        s_n = '0;
                        b_n = b >> 1;
                        if (n == NW'(DBIT-1)) begin
                            state_n = (PARITY != 0) ? ST_PAR : ST_STOP;
                        end else begin
                            n_n = n + NW'(1);
                        end
                    end else begin
                        s_n = s + SW'(1);
                    end
                end
            end
            ST_PAR: begin
                if (s_tick) begin
                    if (s == SW'(15)) begin
                        s_n     = '0;
                        state_n = ST_STOP;
                    end else begin
                        s_n = s + SW'(1);
                    end
                end
            end
            ST_STOP: begin
                if (s_tick) begin
                    if (s == SW'(SB_TICK-1)) begin
                        s_n = '0;
                        // Chain straight into the next frame when a word is waiting
                        if (!empty) begin
                            pop     = 1'b1;
                            b_n     = fifo_dout;
                            p_n     = par_bit;
                            state_n = ST_START;
                        end else begin
                            state_n = ST_IDLE;
                        end
                    end else begin
                        s_n = s + SW'(1);
                    end
                end
            end
            default: begin
                state_n = ST_IDLE;
                s_n     = '0;
                n_n     = '0;
            end
        endcase
    end

    // tx is registered from the next state so it changes on the same edge as the FSM
    always_comb begin
        tx_n   = 1'b1;
        done_n = (state == ST_STOP) && s_tick && (s == SW'(SB_TICK-1));
        case (state_n)
            ST_START: tx_n = 1'b0;
            ST_DATA:  tx_n = b_n[0];
            ST_PAR:   tx_n = p_n;
            default:  tx_n = 1'b1;
        endcase
    end

    assign tx_busy = (state != ST_IDLE) || !empty;

endmodule

// File: tb/tb_uart_tx.sv
// tb/tb_uart_tx.sv - randomized self-checking bench for uart_tx
module tb_uart_tx;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       s_tick = 1'b0;
    logic       tick_en = 1'b1;
    logic [7:0] wdin = 8'h00;
    logic       wvalid = 1'b0;
    int         sel = 0;
    int         checks = 0;
    int         failures = 0;

    logic tx0, rdy0, done0, busy0;
    logic tx1, rdy1, done1, busy1;
    logic tx2, rdy2, done2, busy2;
    logic tx3, rdy3, done3, busy3;
    logic mon_tx, mon_rdy, mon_done, mon_busy;

    always #5 clk = ~clk;

    // s_tick: one clk in sixteen, freezable through tick_en
    initial begin
        int cnt;
        cnt = 0;
        forever begin
            @(posedge clk);
            #1;
            if (tick_en) begin
                cnt = (cnt == 15) ? 0 : cnt + 1;
                s_tick = (cnt == 15);
            end else begin
                s_tick = 1'b0;
            end
        end
    end

    uart_tx u0 (
        .clk(clk), .rst_n(rst_n), .s_tick(s_tick), .din(wdin),
        .din_valid(wvalid && sel == 0), .din_ready(rdy0), .tx(tx0),
        .tx_done_tick(done0), .tx_busy(busy0)
    );
    uart_tx #(.PARITY(1)) u1 (
        .clk(clk), .rst_n(rst_n), .s_tick(s_tick), .din(wdin),
        .din_valid(wvalid && sel == 1), .din_ready(rdy1), .tx(tx1),
        .tx_done_tick(done1), .tx_busy(busy1)
    );
    uart_tx #(.PARITY(2)) u2 (
        .clk(clk), .rst_n(rst_n), .s_tick(s_tick), .din(wdin),
        .din_valid(wvalid && sel == 2), .din_ready(rdy2), .tx(tx2),
        .tx_done_tick(done2), .tx_busy(busy2)
    );
    uart_tx #(.DBIT(7), .SB_TICK(32)) u3 (
        .clk(clk), .rst_n(rst_n), .s_tick(s_tick), .din(wdin[6:0]),
        .din_valid(wvalid && sel == 3), .din_ready(rdy3), .tx(tx3),
        .tx_done_tick(done3), .tx_busy(busy3)
    );

    assign mon_tx   = (sel == 0) ? tx0   : (sel == 1) ? tx1   : (sel == 2) ? tx2   : tx3;
    assign mon_rdy  = (sel == 0) ? rdy0  : (sel == 1) ? rdy1  : (sel == 2) ? rdy2  : rdy3;
    assign mon_done = (sel == 0) ? done0 : (sel == 1) ? done1 : (sel == 2) ? done2 : done3;
    assign mon_busy = (sel == 0) ? busy0 : (sel == 1) ? busy1 : (sel == 2) ? busy2 : busy3;

    task automatic write_word(input logic [7:0] w);
        @(negedge clk);
        wdin   = w;
        wvalid = 1'b1;
        for (int i = 0; i < 20000; i++) begin
            if (mon_rdy) begin
                @(posedge clk);
                #1;
                wvalid = 1'b0;
                return;
            end
            @(negedge clk);
        end
        wvalid = 1'b0;
        checks++;
        failures++;
        $display("FAIL write_timeout din_ready got 0 required 1");
    endtask

    // Reference: a frame is a list of bits, each 16 ticks long, then sb ticks of stop.
    // Position is counted in s_tick pulses so frozen ticks freeze the expected line too.
    task automatic expect_frame(input logic [7:0] w, input int nd, input int par,
                                input int sb, input bit immediate, input string name);
        logic exp_bits [0:10];
        logic bad      [0:10];
        logic badv     [0:10];
        int   nb, ones, j, idx, total;
        logic expv;
        bit   early_done, finished;
        ones = 0;
        nb = 1 + nd + ((par != 0) ? 1 : 0);
        exp_bits[0] = 1'b0;
        for (int i = 0; i < nd; i++) begin
            exp_bits[1+i] = w[i];
            ones += int'(w[i]);
        end
        if (par == 1) exp_bits[1+nd] = logic'(ones % 2);
        if (par == 2) exp_bits[1+nd] = logic'(1 - ones % 2);
        for (int i = 0; i <= 10; i++) begin
            bad[i] = 1'b0;
            badv[i] = 1'b0;
        end
        total = 16 * nb + sb;
        early_done = 0;
        finished = 0;
        if (immediate) begin
            checks++;
            if (mon_tx !== 1'b0) begin
                failures++;
                $display("FAIL %s no_gap_start tx got %b required 0", name, mon_tx);
            end
        end else begin
            for (int i = 0; i < 20000; i++) begin
                if (mon_tx === 1'b0) break;
                @(negedge clk);
            end
        end
        j = 0;
        if (s_tick) j++;
        @(negedge clk);
        for (int i = 0; i < 40000; i++) begin
            idx  = (j < 16 * nb) ? j / 16 : nb;
            expv = (idx < nb) ? exp_bits[idx] : 1'b1;
            if (mon_tx !== expv) begin
                bad[idx]  = 1'b1;
                badv[idx] = mon_tx;
            end
            if (mon_done !== 1'b0) early_done = 1;
            if (s_tick) begin
                j++;
                if (j == total) begin
                    @(negedge clk);
                    checks++;
                    if (mon_done !== 1'b1) begin
                        failures++;
                        $display("FAIL %s done_pulse got %b required 1", name, mon_done);
                    end
                    finished = 1;
                    break;
                end
            end
            @(negedge clk);
        end
        checks++;
        if (!finished) begin
            failures++;
            $display("FAIL %s frame_timeout ticks got %0d required %0d", name, j, total);
        end
        for (int i = 0; i <= nb; i++) begin
            checks++;
            if (bad[i]) begin
                failures++;
                $display("FAIL %s bit%0d tx got %b required %b", name, i, badv[i],
                         (i < nb) ? exp_bits[i] : 1'b1);
            end
        end
        checks++;
        if (early_done) begin
            failures++;
            $display("FAIL %s early_done got 1 required 0", name);
        end
    endtask

    task automatic quiet_after(input string name);
        bit extra;
        extra = 0;
        checks++;
        if (mon_busy !== 1'b0) begin
            failures++;
            $display("FAIL %s busy_after got %b required 0", name, mon_busy);
        end
        for (int i = 0; i < 300; i++) begin
            @(negedge clk);
            if (mon_done !== 1'b0 || mon_tx !== 1'b1) extra = 1;
        end
        checks++;
        if (extra) begin
            failures++;
            $display("FAIL %s idle_after got activity required quiet", name);
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        checks++;
        if ({tx0, tx1, tx2, tx3} !== 4'b1111) begin
            failures++;
            $display("FAIL reset_tx got %b required 1111", {tx0, tx1, tx2, tx3});
        end
        checks++;
        if ({rdy0, busy0, done0} !== 3'b100) begin
            failures++;
            $display("FAIL reset_flags rdy/busy/done got %b required 100", {rdy0, busy0, done0});
        end
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_single();
        logic [7:0] w;
        sel = 0;
        write_word(8'h55);
        expect_frame(8'h55, 8, 0, 16, 0, "single55");
        quiet_after("single55");
        w = 8'($urandom);
        write_word(w);
        expect_frame(w, 8, 0, 16, 0, "single_rand");
        quiet_after("single_rand");
    endtask

    task automatic test_back_to_back();
        sel = 0;
        @(negedge clk);
        tick_en = 1'b0;
        wdin   = 8'h01;
        wvalid = 1'b1;
        for (int k = 1; k <= 4; k++) begin
            for (int i = 0; i < 100 && !mon_rdy; i++) @(negedge clk);
            @(posedge clk);
            #1;
            wdin = 8'(k + 1);
        end
        @(negedge clk);
        checks++;
        if ({mon_rdy, mon_busy, mon_tx} !== 3'b011) begin
            failures++;
            $display("FAIL burst_full rdy/busy/tx got %b required 011", {mon_rdy, mon_busy, mon_tx});
        end
        tick_en = 1'b1;
        fork
            begin
                for (int i = 0; i < 20000 && !mon_rdy; i++) @(negedge clk);
                @(posedge clk);
                #1;
                wvalid = 1'b0;
            end
            begin
                expect_frame(8'h01, 8, 0, 16, 0, "burst1");
                for (int k = 2; k <= 5; k++) begin
                    expect_frame(8'(k), 8, 0, 16, 1, $sformatf("burst%0d", k));
                end
            end
        join
        quiet_after("burst");
    endtask

    task automatic test_parity();
        logic [7:0] w;
        sel = 1;
        write_word(8'h07);
        expect_frame(8'h07, 8, 1, 16, 0, "even07");
        sel = 2;
        write_word(8'h07);
        expect_frame(8'h07, 8, 2, 16, 0, "odd07");
        sel = 1;
        w = 8'($urandom);
        write_word(w);
        expect_frame(w, 8, 1, 16, 0, "even_rand");
        quiet_after("even_rand");
    endtask

    task automatic test_reset_mid();
        bit moved;
        moved = 0;
        sel = 0;
        write_word(8'hA3);
        write_word(8'($urandom));
        write_word(8'($urandom));
        for (int i = 0; i < 20000 && mon_tx !== 1'b0; i++) @(negedge clk);
        repeat (256 + 256 + 100) @(negedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        checks++;
        if (mon_tx !== 1'b1) begin
            failures++;
            $display("FAIL reset_mid_tx got %b required 1", mon_tx);
        end
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        checks++;
        if ({mon_rdy, mon_busy} !== 2'b10) begin
            failures++;
            $display("FAIL reset_mid_flags rdy/busy got %b required 10", {mon_rdy, mon_busy});
        end
        for (int i = 0; i < 600; i++) begin
            @(negedge clk);
            if (mon_tx !== 1'b1 || mon_done !== 1'b0 || mon_busy !== 1'b0) moved = 1;
        end
        checks++;
        if (moved) begin
            failures++;
            $display("FAIL reset_mid_quiet got activity required idle");
        end
    endtask

    task automatic test_tick_gate();
        logic [7:0] w;
        sel = 0;
        w = 8'($urandom);
        write_word(w);
        fork
            expect_frame(w, 8, 0, 16, 0, "gated");
            begin
                logic held;
                bit   changed;
                changed = 0;
                for (int i = 0; i < 20000 && mon_tx !== 1'b0; i++) @(negedge clk);
                repeat (256 * 3 + 50) @(negedge clk);
                tick_en = 1'b0;
                @(negedge clk);
                held = mon_tx;
                for (int i = 0; i < 100; i++) begin
                    @(negedge clk);
                    if (mon_tx !== held) changed = 1;
                end
                tick_en = 1'b1;
                checks++;
                if (changed) begin
                    failures++;
                    $display("FAIL gate_freeze tx got change required hold %b", held);
                end
            end
        join
        quiet_after("gated");
    endtask

    task automatic test_dbit7();
        logic [7:0] w;
        sel = 3;
        write_word(8'h7F);
        expect_frame(8'h7F, 7, 0, 32, 0, "dbit7_7f");
        w = 8'($urandom) & 8'h7F;
        write_word(w);
        expect_frame(w, 7, 0, 32, 0, "dbit7_rand");
        quiet_after("dbit7");
    endtask

    initial begin
        test_reset();
        test_single();
        test_back_to_back();
        test_parity();
        test_reset_mid();
        test_tick_gate();
        test_dbit7();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
